// File: rtl/if_prefetch_queue_pkg.sv
// Shared constants and helpers for the instruction-fetch prefetch queue.
// Address and data widths stay as module parameters.
package if_prefetch_queue_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int MAX_ADDR_W  = 64;

   // Clears the byte offset; callers narrow the result to their own ADDR_W.
   function automatic logic [MAX_ADDR_W-1:0] align_addr(input logic [MAX_ADDR_W-1:0] addr);
      return {addr[MAX_ADDR_W-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/if_prefetch_queue_fifo.sv
// First-word-fall-through queue of {instruction, pc+4} entries with a
// synchronous flush. The producer guarantees it never pushes when full.
module fetch_fifo
   import if_prefetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         push,
   input  logic [WIDTH-1:0]             push_data,
   input  logic                         pop,
   output logic [WIDTH-1:0]             head_data,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   // Storage array; data needs no reset because validity lives in count_r.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
         end
         count_r <= count_r + {{(CNT_W-1){1'b0}}, push} - {{(CNT_W-1){1'b0}}, pop};
      end
   end

   assign head_data = mem_r[rd_ptr_r];
   assign count     = count_r;
   assign empty     = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/if_prefetch_queue.sv
// Instruction prefetch: issues sequential fetches against a credit of free
// queue slots, buffers in-order responses and discards stale ones after a branch.
module if_prefetch_queue
   import if_prefetch_queue_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req_valid,
   input  logic              imem_req_ready,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_resp_valid,
   input  logic [DATA_W-1:0] imem_resp_data,
   input  logic              branch_taken_in,
   input  logic [ADDR_W-1:0] branch_address_in,
   input  logic              freeze_in,
   output logic              out_valid,
   output logic [DATA_W-1:0] instruction_out,
   output logic [ADDR_W-1:0] pc_plus_four_out
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam logic [CNT_W:0]    DEPTH_C = (CNT_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(INSTR_BYTES);
   localparam logic [CNT_W-1:0]  ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [ADDR_W-1:0] fetch_pc_r;
   logic [ADDR_W-1:0] resp_pc_r;
   logic [CNT_W-1:0]  inflight_r;
   logic [CNT_W-1:0]  drop_cnt_r;
   logic              req_valid_r;

   logic [ADDR_W-1:0] branch_pc_s;
   logic [CNT_W-1:0]  occ_s;
   logic [CNT_W-1:0]  occ_next_s;
   logic [CNT_W-1:0]  inflight_next_s;
   logic [CNT_W:0]    credit_sum_s;
   logic              accept_s;
   logic              push_s;
   logic              pop_s;
   logic              empty_s;
   logic [DATA_W+ADDR_W-1:0] push_data_s;
   logic [DATA_W+ADDR_W-1:0] head_data_s;

   assign branch_pc_s = ADDR_W'(align_addr(MAX_ADDR_W'(branch_address_in)));

   // Handshake, queue control and next-cycle credit computation.
   always_comb begin
      accept_s        = req_valid_r && imem_req_ready;
      pop_s           = !empty_s && !freeze_in && !branch_taken_in;
      push_s          = 1'b0;
      occ_next_s      = {CNT_W{1'b0}};
      inflight_next_s = inflight_r + {{(CNT_W-1){1'b0}}, accept_s}
                        - {{(CNT_W-1){1'b0}}, imem_resp_valid};
      if (imem_resp_valid && !branch_taken_in && (drop_cnt_r == {CNT_W{1'b0}})) begin
         push_s = 1'b1;
      end else begin
         push_s = 1'b0;
      end
      if (branch_taken_in) begin
         occ_next_s = {CNT_W{1'b0}};
      end else begin
         occ_next_s = occ_s + {{(CNT_W-1){1'b0}}, push_s} - {{(CNT_W-1){1'b0}}, pop_s};
      end
      credit_sum_s = {1'b0, occ_next_s} + {1'b0, inflight_next_s};
   end

   // PC, credit and drop bookkeeping. The request valid is registered from the
   // next-cycle credit so it has no combinational path from any input.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fetch_pc_r  <= RESET_PC;
         resp_pc_r   <= RESET_PC;
         inflight_r  <= {CNT_W{1'b0}};
         drop_cnt_r  <= {CNT_W{1'b0}};
         req_valid_r <= 1'b0;
      end else begin
         req_valid_r <= (credit_sum_s < DEPTH_C);
         inflight_r  <= inflight_next_s;
         if (branch_taken_in) begin
            fetch_pc_r <= branch_pc_s;
            resp_pc_r  <= branch_pc_s;
            drop_cnt_r <= inflight_next_s;
         end else begin
            if (accept_s) begin
               fetch_pc_r <= fetch_pc_r + STEP_C;
            end
            if (imem_resp_valid) begin
               if (drop_cnt_r != {CNT_W{1'b0}}) begin
                  drop_cnt_r <= drop_cnt_r - ONE_C;
               end else begin
                  resp_pc_r <= resp_pc_r + STEP_C;
               end
            end
         end
      end
   end

   assign push_data_s = {imem_resp_data, {resp_pc_r[ADDR_W-1:2], 2'b00} + STEP_C};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DATA_W + ADDR_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (branch_taken_in),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head_data (head_data_s),
      .count     (occ_s),
      .empty     (empty_s)
   );

   assign imem_req_valid   = req_valid_r;
   assign imem_req_addr    = {fetch_pc_r[ADDR_W-1:2], 2'b00};
   assign out_valid        = !empty_s;
   assign instruction_out  = head_data_s[ADDR_W +: DATA_W];
   assign pc_plus_four_out = head_data_s[ADDR_W-1:0];

endmodule

// File: doc/if_prefetch_queue.md
IF_PREFETCH_QUEUE -- requirements
Module: if_prefetch_queue

Interface
REQ-001 Parameter ADDR_W, default 32: width of PC and memory address.
REQ-002 Parameter DATA_W, default 32: instruction word width.
REQ-003 Parameter DEPTH, default 4: prefetch queue entries; a power of two, at least 2.
REQ-004 Parameter RESET_PC, default 0: fetch address after reset.
REQ-005 The clock port SHALL be clk, input, 1 bit; all state changes on its rising edge.
REQ-006 The reset port SHALL be rst, input, 1 bit; asynchronous, active-low.
REQ-007 imem_req_valid, output, 1 bit: fetch request present.
REQ-008 imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-009 imem_req_addr, output, ADDR_W bits: word-aligned fetch address.
REQ-010 imem_resp_valid, input, 1 bit: one instruction returned, in request order, at least 1 cycle after acceptance.
REQ-011 imem_resp_data, input, DATA_W bits: returned instruction.
REQ-012 branch_taken_in, input, 1 bit: redirect fetch.
REQ-013 branch_address_in, input, ADDR_W bits: redirect target.
REQ-014 freeze_in, input, 1 bit: downstream stalls; head entry is held.
REQ-015 out_valid, output, 1 bit: head entry valid.
REQ-016 instruction_out, output, DATA_W bits: head instruction.
REQ-017 pc_plus_four_out, output, ADDR_W bits: head instruction address + 4.

Function
REQ-018 Request accept is defined as imem_req_valid && imem_req_ready; fetch_pc SHALL advance by 4 per accept, and imem_req_addr SHALL equal {fetch_pc[ADDR_W-1:2],2'b00}.
REQ-019 imem_req_valid SHALL be driven only from registered state (no combinational path from any input), asserted iff occupancy + inflight < DEPTH.
REQ-020 Inflight SHALL count accepted requests with no response yet; its width SHALL hold 0..DEPTH.
REQ-021 A response with drop_cnt = 0 SHALL be pushed into the queue tagged with resp_pc + 4, and resp_pc SHALL advance by 4; with drop_cnt > 0 it SHALL be discarded and drop_cnt decremented.
REQ-022 Pop SHALL occur when out_valid && !freeze_in && !branch_taken_in; push and pop in one cycle SHALL leave occupancy unchanged.
REQ-023 out_valid SHALL equal (occupancy != 0), and outputs SHALL be driven from the head entry; the queue is first-word-fall-through with no bypass, so latency is response cycle + 1.
REQ-024 On branch_taken_in: the queue SHALL be flushed (occupancy 0), and fetch_pc and resp_pc SHALL load the aligned branch_address_in.
REQ-025 drop_cnt SHALL load the post-cycle inflight count; a request accepted in the branch cycle is included, and a response arriving in the branch cycle is discarded and excluded.
REQ-026 branch_taken_in SHALL override freeze_in and push; back-to-back branches SHALL each re-flush and reload drop_cnt.
REQ-027 Overflow SHALL be impossible by REQ-019; pointer wrap SHALL be modulo DEPTH.

Reset
REQ-028 On rst low, asynchronously: fetch_pc = resp_pc = RESET_PC, occupancy = inflight = drop_cnt = 0, pointers = 0, out_valid = 0, imem_req_valid = 0.
REQ-029 Reset mid-operation SHALL abandon all inflight responses; the memory is reset by the same rst, so no late responses arrive.
REQ-030 The first request SHALL issue in the first cycle after rst deasserts.

Structure
REQ-031 Shared package: INSTR_BYTES = 4 and the aligned-address helper; the widths remain module parameters.
REQ-032 One sub-module, fetch_fifo (parametrised DEPTH x (DATA_W+ADDR_W), FWFT, with synchronous flush); the PC and credit logic live in the top module.

Verification
REQ-033 Memory with zero-wait ready and 1-cycle response, freeze low -> out_valid from cycle 3 and pc_plus_four_out = 4, 8, 12, ... on consecutive cycles.
REQ-034 freeze_in held high for 10 cycles, DEPTH = 4 -> occupancy reaches 4, imem_req_valid falls, head is unchanged, and no request is lost after release.
REQ-035 Branch to 0x93 while 3 requests are inflight -> the next 3 responses are dropped, the first output is pc_plus_four_out = 0x94, and imem_req_addr = 0x90.
REQ-036 Branch in the same cycle as a response, freeze and accept -> the response is discarded, drop_cnt is correct, and the queue is empty the next cycle.
REQ-037 rst asserted low mid-burst with the queue holding 2 entries -> out_valid = 0 immediately, and fetch restarts at RESET_PC.
REQ-038 Random ready/response latency, with a reference model compared per pop -> zero mismatches over 10k cycles.
